pipe_stage_reg: RTL
===================

# pipe_stage_reg

Generic elastic pipeline stage register for the CPU pipeline, replacing the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one parametrised block. It carries an opaque payload plus a control vector with a valid/ready handshake and a two-entry skid buffer, so `in_ready` is registered and full throughput is kept. It supports a synchronous flush and "fire-once" masking of side-effect control bits (memory read/write) while the stage is held.

## Interface
- `DATA_W`, 96: payload width (operands, PC+4, immediate, register indices).
- `CTRL_W`, 16: control vector width (opcode, write enables, selects).
- `SE_MASK`, `CTRL_W'(0)`: per-bit mask of side-effect control bits that may be visible for one cycle only per entry.
- `CNT_W`, 16: width of the performance counters.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `flush`, input, 1: synchronous kill of all held and incoming entries.
- `in_valid`, input, 1: upstream entry valid.
- `in_ready`, output, 1: stage can accept; registered, equals skid-entry-empty.
- `in_data`, input, `DATA_W`: upstream payload.
- `in_ctrl`, input, `CTRL_W`: upstream control.
- `out_valid`, output, 1: main entry valid.
- `out_ready`, input, 1: downstream accepts; low means stall.
- `out_data`, output, `DATA_W`: main entry payload.
- `out_ctrl`, output, `CTRL_W`: main entry control, with side-effect masking applied.
- `stall_cnt`, output, `CNT_W`: count of stall cycles.
- `flush_cnt`, output, `CNT_W`: count of flushes.

## Operation
- Handshake events:
  - Accept = `in_valid && in_ready`.
  - Fire = `out_valid && out_ready`.
  - Stall cycle = `out_valid && !out_ready`.
- Storage is a main entry M (drives the outputs) and a skid entry S. Each has a valid bit, data and control.
- States, encoded by {S.v, M.v}:
  - EMPTY: M and S empty.
  - ONE: M full, S empty.
  - FULL: M and S full.
- Transitions (when flush is low):
  - EMPTY, accept → ONE; M ← in.
  - ONE, accept and fire → ONE; M ← in.
  - ONE, accept and no fire → FULL; S ← in.
  - ONE, fire and no accept → EMPTY.
  - FULL, fire → ONE; M ← S. No accept is possible because `in_ready` is 0.
  - Otherwise hold.
- Flush has priority over every other event.
  - Next state is EMPTY.
  - M and S data and control are cleared to 0.
  - An entry accepted in the same cycle is dropped.
  - A fire in the same cycle still completes downstream.
- Fire-once masking:
  - `out_ctrl = M.ctrl & ~(SE_MASK & {CTRL_W{spent}})`.
  - `spent` is set at the end of any stall cycle.
  - `spent` is cleared whenever M loads a new entry, or on flush.
  - Result: SE bits are visible only in the first cycle an entry is presented. Other control bits and `out_data` hold stable for the whole stall.
- Payload never passes combinationally from input to output.
- Counters:
  - `stall_cnt` increments on each stall cycle.
  - `flush_cnt` increments on each cycle `flush` is high.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (async assert; release synchronous to `clk`):
  - State EMPTY, so `out_valid` = 0 and `in_ready` = 1.
  - `out_data` = 0, `out_ctrl` = 0, `spent` = 0.
  - `stall_cnt` = 0, `flush_cnt` = 0.
- Latency: an entry accepted at edge n is presented on `out_*` after edge n, i.e. 1 cycle.
- Throughput: 1 entry per cycle while `out_ready` = 1.
- `in_ready` deasserts the cycle after S fills. It reasserts the cycle after the fire that moves S into M.
- Reset mid-operation discards all entries with no handshake toward either side.
- Flush takes effect at the edge on which it is sampled: `out_valid` = 0 in the following cycle.

## Configuration
- `PIPE_STAGE_PERF_EN` defined: the two saturating counters are built.
- Not defined: no counter logic is built. `stall_cnt` and `flush_cnt` are tied to 0 so the port list is unchanged.

## Structure
- Package `pipe_pkg` holds:
  - The `pipe_state_e` enum (EMPTY, ONE, FULL).
  - Default widths `PIPE_DATA_W` and `PIPE_CTRL_W`.
  - Per-stage SE mask constants, e.g. `ID_EX_SE_MASK` covering `mem_wr` and `mem_rd`.
- One sub-module: `pipe_sat_counter`, a `CNT_W` saturating incrementer with enable. It is instantiated twice under `PIPE_STAGE_PERF_EN`.

## Test plan
1. Reset with `in_valid` = 1 → `out_valid` = 0, `in_ready` = 1, outputs 0. On the first edge after release, `in_data` = 0xA5 is accepted and `out_data` = 0xA5 one cycle later.
2. Stream 8 entries with `out_ready` = 1 → 8 outputs on consecutive cycles, in order, `in_ready` never low.
3. `SE_MASK` = 0x3, `in_ctrl` = 0x7, `out_ready` held low 3 cycles → `out_ctrl` reads 0x7, then 0x4, 0x4, and stays 0x4 until fire. `stall_cnt` = 3.
4. Stall with M full, accept one more → `in_ready` = 0 the next cycle. Raise `out_ready` → outputs M then S in order, and `in_ready` = 1 after the first fire.
5. FULL state with `flush` = 1, `in_valid` = 1, `out_ready` = 0 → next cycle `out_valid` = 0, `in_ready` = 1, `out_data`/`out_ctrl` = 0. The incoming entry is never presented, and `flush_cnt` = 1.
6. With `CNT_W` = 2, hold a stall for 6 cycles → `stall_cnt` sticks at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage registers.
package pipe_pkg;

  // Encoded as {skid valid, main valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } pipe_state_e;

  localparam int unsigned PIPE_DATA_W = 96;
  localparam int unsigned PIPE_CTRL_W = 16;

  localparam int unsigned CTRL_MEM_RD = 0;
  localparam int unsigned CTRL_MEM_WR = 1;

  localparam logic [PIPE_CTRL_W-1:0] IF_ID_SE_MASK  = '0;
  localparam logic [PIPE_CTRL_W-1:0] ID_EX_SE_MASK  = (16'b1 << CTRL_MEM_RD) | (16'b1 << CTRL_MEM_WR);
  localparam logic [PIPE_CTRL_W-1:0] EX_MEM_SE_MASK = (16'b1 << CTRL_MEM_RD) | (16'b1 << CTRL_MEM_WR);
  localparam logic [PIPE_CTRL_W-1:0] MEM_WB_SE_MASK = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable; only compiled with PIPE_STAGE_PERF_EN
// because it is instantiated nowhere else.
`ifdef PIPE_STAGE_PERF_EN
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main entry plus skid entry, registered in_ready,
// flush, fire-once side-effect masking. PIPE_STAGE_PERF_EN builds the perf counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = PIPE_DATA_W,
  parameter int unsigned       CTRL_W  = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] SE_MASK = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              spent_q, spent_d;

  logic accept;
  logic fire;
  logic stall;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign stall     = out_valid && !out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    spent_d  = spent_q | stall;
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = '0;
      m_ctrl_d = '0;
      s_data_d = '0;
      s_ctrl_d = '0;
      spent_d  = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
            spent_d  = 1'b0;
          end
        end
        ONE: begin
          if (accept && fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
            spent_d  = 1'b0;
          end else if (accept) begin
            state_d  = FULL;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen
          if (fire) begin
            state_d  = ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            s_data_d = '0;
            s_ctrl_d = '0;
            spent_d  = 1'b0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
      spent_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      spent_q  <= spent_d;
    end
  end

  assign out_data = m_data_q;
  assign out_ctrl = m_ctrl_q & ~(SE_MASK & {CTRL_W{spent_q}});

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
